noc_node_ni: RTL and testbench



---
 rtl/noc_pkg.sv | 17 +
 rtl/ni_fifo.sv | 56 +++++
 rtl/noc_node_ni.sv | 174 +++++++++++++++++
 tb/tb_noc_node_ni.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared constants for the NoC node network interface.
package noc_pkg;

   localparam int unsigned FLIT_W_DEF    = 20;

   // Destination field sits at the top of the flit: {dst_cluster, dst_local}
   localparam int unsigned DST_CLUSTER_W = 2;
   localparam int unsigned DST_LOCAL_W   = 2;
   localparam int unsigned DST_W         = DST_CLUSTER_W + DST_LOCAL_W;

   // Sticky error flag bit positions
   localparam int unsigned ERR_W         = 3;
   localparam int unsigned ERR_EJ_OVF    = 0;
   localparam int unsigned ERR_CRED_OVF  = 1;
   localparam int unsigned ERR_MISROUTE  = 2;

endpackage

// File: rtl/ni_fifo.sv
// Synchronous first-word-fall-through FIFO; a push at full is accepted when a pop
// happens in the same cycle.
module ni_fifo #(
   parameter int unsigned WIDTH = 20,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign rdata = mem[rd_ptr];

   // Storage, pointers and occupancy; storage is cleared so the head reads zero out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/noc_node_ni.sv
// Network interface between a router local port and its PE: credit-gated injection,
// ejection buffering with credit return, traffic counters and sticky error flags.
// Optional feature: define NI_DEST_CHECK_EN to drop and flag misrouted ejected flits.
module noc_node_ni
   import noc_pkg::*;
#(
   parameter int unsigned FLIT_W    = FLIT_W_DEF,
   parameter int unsigned INJ_DEPTH = 4,
   parameter int unsigned EJ_DEPTH  = 4,
   parameter int unsigned CREDITS   = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        my_cluster,
   input  logic [1:0]        my_local,
   input  logic [FLIT_W-1:0] pe_tx_data,
   input  logic              pe_tx_valid,
   output logic              pe_tx_ready,
   output logic [FLIT_W-1:0] rtr_in_data,
   output logic              rtr_in_valid,
   input  logic              rtr_credit_in,
   input  logic [FLIT_W-1:0] rtr_out_data,
   input  logic              rtr_out_valid,
   output logic              rtr_credit_out,
   output logic [FLIT_W-1:0] pe_rx_data,
   output logic              pe_rx_valid,
   input  logic              pe_rx_ready,
   output logic [CNT_W-1:0]  tx_count,
   output logic [CNT_W-1:0]  rx_count,
   output logic [ERR_W-1:0]  err
);

   localparam int unsigned CRW = $clog2(CREDITS + 1);
   localparam int unsigned PW  = $clog2(EJ_DEPTH + 4);

   // ---------------- injection path ----------------
   logic              inj_full;
   logic              inj_empty;
   logic              inj_push;
   logic              inj_pop;
   logic [FLIT_W-1:0] inj_head;
   logic              pe_acc;
   logic              have_credit;
   logic              send;
   logic              bypass;
   logic [FLIT_W-1:0] send_data;
   logic [CRW-1:0]    credit_cnt;
   logic              cred_ovf;

   assign pe_tx_ready = !inj_full;
   assign pe_acc      = pe_tx_valid && !inj_full;
   assign have_credit = (credit_cnt != '0);
   // An empty FIFO lets an accepted flit go straight to the router in the same cycle
   assign send        = have_credit && (!inj_empty || pe_acc);
   assign bypass      = send && inj_empty;
   assign inj_push    = pe_acc && !bypass;
   assign inj_pop     = send && !inj_empty;
   assign send_data   = inj_empty ? pe_tx_data : inj_head;
   assign cred_ovf    = rtr_credit_in && !send && (credit_cnt == CRW'(CREDITS));

   ni_fifo #(.WIDTH(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inj_push),
      .wdata (pe_tx_data),
      .pop   (inj_pop),
      .rdata (inj_head),
      .full  (inj_full),
      .empty (inj_empty)
   );

   // Send credit tracking; a credit arriving when already full is ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_cnt <= CRW'(CREDITS);
      end else begin
         case ({send, rtr_credit_in})
            2'b10:   credit_cnt <= credit_cnt - CRW'(1);
            2'b01:   if (!cred_ovf) credit_cnt <= credit_cnt + CRW'(1);
            default: credit_cnt <= credit_cnt;
         endcase
      end
   end

   // Registered send strobe, flit and transmit counter
   always_ff @(posedge clk) begin
      if (rst) begin
         rtr_in_valid <= 1'b0;
         rtr_in_data  <= '0;
         tx_count     <= '0;
      end else begin
         rtr_in_valid <= send;
         if (send) begin
            rtr_in_data <= send_data;
            tx_count    <= tx_count + CNT_W'(1);
         end
      end
   end

   // ---------------- ejection path ----------------
   logic              ej_full;
   logic              ej_empty;
   logic              ej_push;
   logic              ej_pop;
   logic              ej_ovf;
   logic              dest_ok;
   logic              misroute;
   logic [PW-1:0]     credit_pending;
   logic [PW-1:0]     credit_sum;
   logic              credit_fire;

`ifdef NI_DEST_CHECK_EN
   assign dest_ok  = (rtr_out_data[FLIT_W-1 -: DST_W] == {my_cluster, my_local});
   assign misroute = rtr_out_valid && !dest_ok;
`else
   logic unused_addr;
   assign unused_addr = ^{my_cluster, my_local};
   assign dest_ok     = 1'b1;
   assign misroute    = 1'b0;
`endif

   assign pe_rx_valid = !ej_empty;
   assign ej_pop      = !ej_empty && pe_rx_ready;
   assign ej_push     = rtr_out_valid && dest_ok;
   assign ej_ovf      = ej_push && ej_full && !ej_pop;

   ni_fifo #(.WIDTH(FLIT_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ej_push),
      .wdata (rtr_out_data),
      .pop   (ej_pop),
      .rdata (pe_rx_data),
      .full  (ej_full),
      .empty (ej_empty)
   );

   // Credits owed this cycle include new ones, so a pop with nothing pending pulses next cycle
   assign credit_sum  = credit_pending + PW'(ej_pop) + PW'(misroute);
   assign credit_fire = (credit_sum != '0);

   // Credit return: at most one pulse per cycle, surplus drains on later cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_pending <= '0;
         rtr_credit_out <= 1'b0;
      end else begin
         credit_pending <= credit_sum - PW'(credit_fire);
         rtr_credit_out <= credit_fire;
      end
   end

   // Delivered-flit counter
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_count <= '0;
      end else if (ej_pop) begin
         rx_count <= rx_count + CNT_W'(1);
      end
   end

   // Sticky protocol error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= '0;
      end else begin
         if (ej_ovf)   err[ERR_EJ_OVF]   <= 1'b1;
         if (cred_ovf) err[ERR_CRED_OVF] <= 1'b1;
         if (misroute) err[ERR_MISROUTE] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_noc_node_ni.sv
// Directed self-checking bench for noc_node_ni (default parameters).
module tb_noc_node_ni;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  my_cluster;
   logic [1:0]  my_local;
   logic [19:0] pe_tx_data;
   logic        pe_tx_valid;
   logic        pe_tx_ready;
   logic [19:0] rtr_in_data;
   logic        rtr_in_valid;
   logic        rtr_credit_in;
   logic [19:0] rtr_out_data;
   logic        rtr_out_valid;
   logic        rtr_credit_out;
   logic [19:0] pe_rx_data;
   logic        pe_rx_valid;
   logic        pe_rx_ready;
   logic [15:0] tx_count;
   logic [15:0] rx_count;
   logic [2:0]  err;

   int total = 0;
   int bad   = 0;

   noc_node_ni dut (
      .clk            (clk),
      .rst            (rst),
      .my_cluster     (my_cluster),
      .my_local       (my_local),
      .pe_tx_data     (pe_tx_data),
      .pe_tx_valid    (pe_tx_valid),
      .pe_tx_ready    (pe_tx_ready),
      .rtr_in_data    (rtr_in_data),
      .rtr_in_valid   (rtr_in_valid),
      .rtr_credit_in  (rtr_credit_in),
      .rtr_out_data   (rtr_out_data),
      .rtr_out_valid  (rtr_out_valid),
      .rtr_credit_out (rtr_credit_out),
      .pe_rx_data     (pe_rx_data),
      .pe_rx_valid    (pe_rx_valid),
      .pe_rx_ready    (pe_rx_ready),
      .tx_count       (tx_count),
      .rx_count       (rx_count),
      .err            (err)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 ns after the rising edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      my_cluster    = 2'd2;
      my_local      = 2'd1;
      pe_tx_data    = '0;
      pe_tx_valid   = 1'b0;
      rtr_credit_in = 1'b0;
      rtr_out_data  = '0;
      rtr_out_valid = 1'b0;
      pe_rx_ready   = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      total++; if (pe_tx_ready !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got=%b exp=1", pe_tx_ready); end
      total++; if (rtr_in_valid !== 1'b0) begin bad++; $display("FAIL rst_in_valid got=%b exp=0", rtr_in_valid); end
      total++; if (rtr_in_data !== 20'h0) begin bad++; $display("FAIL rst_in_data got=%h exp=0", rtr_in_data); end
      total++; if (rtr_credit_out !== 1'b0) begin bad++; $display("FAIL rst_credit_out got=%b exp=0", rtr_credit_out); end
      total++; if (pe_rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b exp=0", pe_rx_valid); end
      total++; if (pe_rx_data !== 20'h0) begin bad++; $display("FAIL rst_rx_data got=%h exp=0", pe_rx_data); end
      total++; if (tx_count !== 16'd0) begin bad++; $display("FAIL rst_tx_count got=%0d exp=0", tx_count); end
      total++; if (rx_count !== 16'd0) begin bad++; $display("FAIL rst_rx_count got=%0d exp=0", rx_count); end
      total++; if (err !== 3'b000) begin bad++; $display("FAIL rst_err got=%b exp=000", err); end
      total++; if (dut.credit_cnt !== 3'd4) begin bad++; $display("FAIL rst_credit_cnt got=%0d exp=4", dut.credit_cnt); end
   endtask

   task automatic test_single_send;
      do_reset();
      pe_tx_data  = 20'h5A5A5;
      pe_tx_valid = 1'b1;
      tick();
      pe_tx_valid = 1'b0;
      total++; if (rtr_in_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rtr_in_valid); end
      total++; if (rtr_in_data !== 20'h5A5A5) begin bad++; $display("FAIL single_data got=%h exp=5a5a5", rtr_in_data); end
      total++; if (tx_count !== 16'd1) begin bad++; $display("FAIL single_tx_count got=%0d exp=1", tx_count); end
      tick();
      total++; if (rtr_in_valid !== 1'b0) begin bad++; $display("FAIL single_strobe_len got=%b exp=0", rtr_in_valid); end
      total++; if (dut.credit_cnt !== 3'd3) begin bad++; $display("FAIL single_credit got=%0d exp=3", dut.credit_cnt); end
      rtr_credit_in = 1'b1;
      tick();
      rtr_credit_in = 1'b0;
      total++; if (dut.credit_cnt !== 3'd4) begin bad++; $display("FAIL single_credit_ret got=%0d exp=4", dut.credit_cnt); end
      total++; if (err !== 3'b000) begin bad++; $display("FAIL single_err got=%b exp=000", err); end
   endtask

   task automatic test_credit_gating;
      logic [19:0] exp_d;
      int          sent;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         pe_tx_data  = 20'h90100 + 20'(i);
         pe_tx_valid = 1'b1;
         tick();
         total++; if (rtr_in_valid !== (i < 4)) begin bad++; $display("FAIL gate_valid[%0d] got=%b exp=%b", i, rtr_in_valid, (i < 4)); end
         if (i < 4) begin
            exp_d = 20'h90100 + 20'(i);
            total++; if (rtr_in_data !== exp_d) begin bad++; $display("FAIL gate_data[%0d] got=%h exp=%h", i, rtr_in_data, exp_d); end
         end
      end
      pe_tx_valid = 1'b0;
      sent = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rtr_in_valid === 1'b1) sent++;
      end
      total++; if (sent != 0) begin bad++; $display("FAIL gate_no_credit_sends got=%0d exp=0", sent); end
      total++; if (tx_count !== 16'd4) begin bad++; $display("FAIL gate_tx_count got=%0d exp=4", tx_count); end
      for (int k = 0; k < 2; k++) begin
         rtr_credit_in = 1'b1;
         tick();
         rtr_credit_in = 1'b0;
         total++; if (rtr_in_valid !== 1'b0) begin bad++; $display("FAIL gate_early[%0d] got=%b exp=0", k, rtr_in_valid); end
         tick();
         exp_d = 20'h90104 + 20'(k);
         total++; if (rtr_in_valid !== 1'b1) begin bad++; $display("FAIL gate_resume[%0d] got=%b exp=1", k, rtr_in_valid); end
         total++; if (rtr_in_data !== exp_d) begin bad++; $display("FAIL gate_resume_data[%0d] got=%h exp=%h", k, rtr_in_data, exp_d); end
      end
      total++; if (tx_count !== 16'd6) begin bad++; $display("FAIL gate_tx_total got=%0d exp=6", tx_count); end
      total++; if (dut.credit_cnt !== 3'd0) begin bad++; $display("FAIL gate_credit_end got=%0d exp=0", dut.credit_cnt); end
   endtask

   task automatic test_inj_full;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         pe_tx_data  = 20'(i);
         pe_tx_valid = 1'b1;
         tick();
      end
      total++; if (pe_tx_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", pe_tx_ready); end
      pe_tx_data = 20'hABCDE;
      tick();
      total++; if (pe_tx_ready !== 1'b0) begin bad++; $display("FAIL full_hold got=%b exp=0", pe_tx_ready); end
      rtr_credit_in = 1'b1;
      tick();
      rtr_credit_in = 1'b0;
      total++; if (pe_tx_ready !== 1'b0) begin bad++; $display("FAIL full_after_credit got=%b exp=0", pe_tx_ready); end
      tick();
      total++; if (rtr_in_valid !== 1'b1) begin bad++; $display("FAIL full_send got=%b exp=1", rtr_in_valid); end
      total++; if (rtr_in_data !== 20'h00004) begin bad++; $display("FAIL full_send_data got=%h exp=00004", rtr_in_data); end
      total++; if (pe_tx_ready !== 1'b1) begin bad++; $display("FAIL full_slot_free got=%b exp=1", pe_tx_ready); end
      tick();
      pe_tx_valid = 1'b0;
      total++; if (pe_tx_ready !== 1'b0) begin bad++; $display("FAIL full_refill got=%b exp=0", pe_tx_ready); end
   endtask

   task automatic test_ej_overflow;
      logic [19:0] exp_d;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         rtr_out_data  = 20'h90000 + 20'(i);
         rtr_out_valid = 1'b1;
         tick();
         if (i == 0) begin
            total++; if (pe_rx_valid !== 1'b1) begin bad++; $display("FAIL ej_rx_valid got=%b exp=1", pe_rx_valid); end
            total++; if (pe_rx_data !== 20'h90000) begin bad++; $display("FAIL ej_rx_data got=%h exp=90000", pe_rx_data); end
         end
      end
      rtr_out_valid = 1'b0;
      total++; if (err !== 3'b001) begin bad++; $display("FAIL ej_ovf_err got=%b exp=001", err); end
      for (int i = 0; i < 4; i++) begin
         pe_rx_ready = 1'b1;
         exp_d = 20'h90000 + 20'(i);
         total++; if (pe_rx_data !== exp_d) begin bad++; $display("FAIL ej_pop_data[%0d] got=%h exp=%h", i, pe_rx_data, exp_d); end
         tick();
         total++; if (rtr_credit_out !== 1'b1) begin bad++; $display("FAIL ej_credit[%0d] got=%b exp=1", i, rtr_credit_out); end
      end
      pe_rx_ready = 1'b0;
      total++; if (pe_rx_valid !== 1'b0) begin bad++; $display("FAIL ej_drained got=%b exp=0", pe_rx_valid); end
      tick();
      total++; if (rtr_credit_out !== 1'b0) begin bad++; $display("FAIL ej_credit_end got=%b exp=0", rtr_credit_out); end
      total++; if (rx_count !== 16'd4) begin bad++; $display("FAIL ej_rx_count got=%0d exp=4", rx_count); end
   endtask

   task automatic test_ej_full_pushpop;
      logic [19:0] exp_d;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rtr_out_data  = 20'h90010 + 20'(i);
         rtr_out_valid = 1'b1;
         tick();
      end
      rtr_out_data = 20'h90014;
      pe_rx_ready  = 1'b1;
      tick();
      rtr_out_valid = 1'b0;
      pe_rx_ready   = 1'b0;
      total++; if (err !== 3'b000) begin bad++; $display("FAIL pp_err got=%b exp=000", err); end
      total++; if (pe_rx_data !== 20'h90011) begin bad++; $display("FAIL pp_head got=%h exp=90011", pe_rx_data); end
      pe_rx_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         exp_d = 20'h90010 + 20'(i);
         total++; if (pe_rx_data !== exp_d) begin bad++; $display("FAIL pp_data[%0d] got=%h exp=%h", i, pe_rx_data, exp_d); end
         tick();
      end
      pe_rx_ready = 1'b0;
      total++; if (rx_count !== 16'd5) begin bad++; $display("FAIL pp_rx_count got=%0d exp=5", rx_count); end
   endtask

   task automatic test_credit_overflow;
      do_reset();
      pe_tx_data    = 20'h12345;
      pe_tx_valid   = 1'b1;
      rtr_credit_in = 1'b1;
      tick();
      pe_tx_valid   = 1'b0;
      total++; if (rtr_in_valid !== 1'b1) begin bad++; $display("FAIL cov_send got=%b exp=1", rtr_in_valid); end
      total++; if (dut.credit_cnt !== 3'd4) begin bad++; $display("FAIL cov_same_cycle got=%0d exp=4", dut.credit_cnt); end
      total++; if (err !== 3'b000) begin bad++; $display("FAIL cov_no_err got=%b exp=000", err); end
      tick();
      rtr_credit_in = 1'b0;
      total++; if (err !== 3'b010) begin bad++; $display("FAIL cov_err got=%b exp=010", err); end
      total++; if (dut.credit_cnt !== 3'd4) begin bad++; $display("FAIL cov_credit got=%0d exp=4", dut.credit_cnt); end
   endtask

   task automatic test_misroute;
`ifdef NI_DEST_CHECK_EN
      do_reset();
      rtr_out_data  = 20'h71234;
      rtr_out_valid = 1'b1;
      tick();
      rtr_out_valid = 1'b0;
      total++; if (pe_rx_valid !== 1'b0) begin bad++; $display("FAIL mis_stored got=%b exp=0", pe_rx_valid); end
      total++; if (err !== 3'b100) begin bad++; $display("FAIL mis_err got=%b exp=100", err); end
      total++; if (rtr_credit_out !== 1'b1) begin bad++; $display("FAIL mis_credit got=%b exp=1", rtr_credit_out); end
      tick();
      total++; if (rtr_credit_out !== 1'b0) begin bad++; $display("FAIL mis_credit_end got=%b exp=0", rtr_credit_out); end
      do_reset();
      rtr_out_data  = 20'h90001;
      rtr_out_valid = 1'b1;
      tick();
      rtr_out_data  = 20'h70000;
      pe_rx_ready   = 1'b1;
      tick();
      rtr_out_valid = 1'b0;
      pe_rx_ready   = 1'b0;
      total++; if (rtr_credit_out !== 1'b1) begin bad++; $display("FAIL mis2_first got=%b exp=1", rtr_credit_out); end
      total++; if (rx_count !== 16'd1) begin bad++; $display("FAIL mis2_rx_count got=%0d exp=1", rx_count); end
      tick();
      total++; if (rtr_credit_out !== 1'b1) begin bad++; $display("FAIL mis2_second got=%b exp=1", rtr_credit_out); end
      tick();
      total++; if (rtr_credit_out !== 1'b0) begin bad++; $display("FAIL mis2_end got=%b exp=0", rtr_credit_out); end
`else
      do_reset();
      rtr_out_data  = 20'h71234;
      rtr_out_valid = 1'b1;
      tick();
      rtr_out_valid = 1'b0;
      total++; if (pe_rx_valid !== 1'b1) begin bad++; $display("FAIL nochk_stored got=%b exp=1", pe_rx_valid); end
      total++; if (pe_rx_data !== 20'h71234) begin bad++; $display("FAIL nochk_data got=%h exp=71234", pe_rx_data); end
      total++; if (err !== 3'b000) begin bad++; $display("FAIL nochk_err got=%b exp=000", err); end
      pe_rx_ready = 1'b1;
      tick();
      pe_rx_ready = 1'b0;
      total++; if (rtr_credit_out !== 1'b1) begin bad++; $display("FAIL nochk_credit got=%b exp=1", rtr_credit_out); end
`endif
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single_send();
      test_credit_gating();
      test_inj_full();
      test_ej_overflow();
      test_ej_full_pushpop();
      test_credit_overflow();
      test_misroute();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
